// File: rtl/apb_cache_ctrl_pkg.sv
// Shared constants for the APB instruction-cache control block: register
// offsets, STATUS/CNT_CTRL bit positions and flush-sequencer state codes.
package apb_cache_ctrl_pkg;

  localparam int OFF_ENABLE   = 'h00;
  localparam int OFF_FLUSH    = 'h04;
  localparam int OFF_STATUS   = 'h08;
  localparam int OFF_TIMEOUT  = 'h0C;
  localparam int OFF_CNT_CTRL = 'h10;
  localparam int OFF_CNT_BASE = 'h20;  // HIT[i] at base+8*i, MISS[i] at base+8*i+4

  localparam int STATUS_BUSY_BIT   = 0;
  localparam int STATUS_DONE_BIT   = 1;
  localparam int STATUS_IRQ_EN_BIT = 2;

  localparam int CNT_CTRL_EN_BIT  = 0;
  localparam int CNT_CTRL_CLR_BIT = 1;

  localparam logic [1:0] FSM_IDLE = 2'd0;
  localparam logic [1:0] FSM_REQ  = 2'd1;
  localparam logic [1:0] FSM_WAIT = 2'd2;

  // Registers are word-decoded, so offsets are compared as word indices.
  function automatic int word_of(input int byte_off);
    return byte_off / 4;
  endfunction

endpackage

// File: rtl/cache_flush_seq.sv
// Flush sequencer: queues per-core flush requests and serves them one at a
// time, lowest core first, with an ack handshake and a bounded wait.
module cache_flush_seq
  import apb_cache_ctrl_pkg::*;
#(
  parameter int NUM_CORES     = 4,
  parameter int FLUSH_TIMEOUT = 1024
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [NUM_CORES-1:0] set_i,
  input  logic [NUM_CORES-1:0] ack_i,
  output logic [NUM_CORES-1:0] flush_req_o,
  output logic [NUM_CORES-1:0] pending_o,
  output logic                 busy_o,
  output logic                 done_set_o,
  output logic [NUM_CORES-1:0] timeout_set_o
);

  localparam int TW = $clog2(FLUSH_TIMEOUT + 1);

  logic [1:0]           state_q, state_d;
  logic [NUM_CORES-1:0] pending_q, pending_d;
  logic [NUM_CORES-1:0] active_q, active_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [NUM_CORES-1:0] pick;
  logic [NUM_CORES-1:0] pending_merged;

  // Two's-complement trick isolates the lowest set bit as a one-hot mask.
  assign pick           = pending_q & (~pending_q + NUM_CORES'(1));
  assign pending_merged = pending_q | set_i;

  // NOTE: every always_comb output gets a default first so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_merged;
    active_d      = active_q;
    timer_d       = timer_q;
    done_set_o    = 1'b0;
    timeout_set_o = '0;
    case (state_q)
      FSM_IDLE: begin
        if (pending_q != '0) begin
          active_d  = pick;
          pending_d = (pending_q & ~pick) | set_i;
          state_d   = FSM_REQ;
        end
      end
      FSM_REQ: begin
        timer_d = TW'(FLUSH_TIMEOUT);
        state_d = FSM_WAIT;
      end
      FSM_WAIT: begin
        if ((ack_i & active_q) != '0) begin
          state_d    = FSM_IDLE;
          done_set_o = (pending_merged == '0);
        end else if (timer_q == '0) begin
          timeout_set_o = active_q;
          state_d       = FSM_IDLE;
          done_set_o    = (pending_merged == '0);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = FSM_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= FSM_IDLE;
      pending_q <= '0;
      active_q  <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      timer_q   <= timer_d;
    end
  end

  assign busy_o      = (state_q != FSM_IDLE);
  assign flush_req_o = busy_o ? active_q : '0;
  assign pending_o   = pending_q;

endmodule

// File: rtl/apb_cache_ctrl_mc.sv
// APB register block for NUM_CORES private instruction caches: enables,
// queued flushes with done interrupt, and saturating hit/miss counters.
module apb_cache_ctrl_mc
  import apb_cache_ctrl_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_CORES      = 4,
  parameter int CNT_WIDTH      = 32,
  parameter int FLUSH_TIMEOUT  = 1024
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic [NUM_CORES-1:0]      ic_enable_o,
  output logic [NUM_CORES-1:0]      ic_flush_req_o,
  input  logic [NUM_CORES-1:0]      ic_flush_ack_i,
  input  logic [NUM_CORES-1:0]      ic_hit_i,
  input  logic [NUM_CORES-1:0]      ic_miss_i,
  output logic                      irq_o
);

  localparam int WW = APB_ADDR_WIDTH - 2;

  logic [WW-1:0]        word;
  logic                 access, wr;
  logic                 sel_enable, sel_flush, sel_status, sel_timeout, sel_cnt_ctrl;
  logic                 mapped;
  logic [31:0]          rdata;
  logic                 unused_apb;

  logic [NUM_CORES-1:0] enable_q, timeout_q;
  logic                 done_q, irq_en_q, cnt_en_q;
  logic [CNT_WIDTH-1:0] hit_q  [NUM_CORES];
  logic [CNT_WIDTH-1:0] miss_q [NUM_CORES];

  logic [NUM_CORES-1:0] pending, timeout_set, flush_set;
  logic                 busy, done_set, cnt_clr;

  assign word         = PADDR[APB_ADDR_WIDTH-1:2];
  assign access       = PSEL & PENABLE;
  assign wr           = access & PWRITE;
  assign sel_enable   = (word == WW'(word_of(OFF_ENABLE)));
  assign sel_flush    = (word == WW'(word_of(OFF_FLUSH)));
  assign sel_status   = (word == WW'(word_of(OFF_STATUS)));
  assign sel_timeout  = (word == WW'(word_of(OFF_TIMEOUT)));
  assign sel_cnt_ctrl = (word == WW'(word_of(OFF_CNT_CTRL)));
  assign unused_apb   = ^{PADDR[1:0], PWDATA};

  assign flush_set = (wr & sel_flush) ? PWDATA[NUM_CORES-1:0] : '0;
  assign cnt_clr   = wr & sel_cnt_ctrl & PWDATA[CNT_CTRL_CLR_BIT];

  cache_flush_seq #(
    .NUM_CORES    (NUM_CORES),
    .FLUSH_TIMEOUT(FLUSH_TIMEOUT)
  ) u_flush_seq (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .set_i        (flush_set),
    .ack_i        (ic_flush_ack_i),
    .flush_req_o  (ic_flush_req_o),
    .pending_o    (pending),
    .busy_o       (busy),
    .done_set_o   (done_set),
    .timeout_set_o(timeout_set)
  );

  always_comb begin
    rdata  = '0;
    mapped = 1'b1;
    if (sel_enable) begin
      rdata = 32'(enable_q);
    end else if (sel_flush) begin
      rdata = 32'(pending | ic_flush_req_o);
    end else if (sel_status) begin
      rdata[STATUS_BUSY_BIT]   = busy;
      rdata[STATUS_DONE_BIT]   = done_q;
      rdata[STATUS_IRQ_EN_BIT] = irq_en_q;
    end else if (sel_timeout) begin
      rdata = 32'(timeout_q);
    end else if (sel_cnt_ctrl) begin
      rdata[CNT_CTRL_EN_BIT] = cnt_en_q;
    end else begin
      mapped = 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (word == WW'(word_of(OFF_CNT_BASE + 8 * i))) begin
          mapped = 1'b1;
          rdata  = 32'(hit_q[i]);
        end
        if (word == WW'(word_of(OFF_CNT_BASE + 8 * i + 4))) begin
          mapped = 1'b1;
          rdata  = 32'(miss_q[i]);
        end
      end
    end
  end

  assign PRDATA  = access ? rdata : '0;
  assign PSLVERR = access & ~mapped;
  assign PREADY  = 1'b1;

  // Hardware set events win over same-cycle software clears.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      enable_q  <= '0;
      timeout_q <= '0;
      done_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      cnt_en_q  <= 1'b0;
      // NOTE: the counter arrays are reset because software reads them as
      // absolute event counts from a known zero.
      for (int i = 0; i < NUM_CORES; i++) begin
        hit_q[i]  <= '0;
        miss_q[i] <= '0;
      end
    end else begin
      if (wr & sel_enable) enable_q <= PWDATA[NUM_CORES-1:0];
      if (wr & sel_status) irq_en_q <= PWDATA[STATUS_IRQ_EN_BIT];
      if (wr & sel_cnt_ctrl) cnt_en_q <= PWDATA[CNT_CTRL_EN_BIT];
      done_q    <= done_set | (done_q & ~(wr & sel_status & PWDATA[STATUS_DONE_BIT]));
      timeout_q <= timeout_set |
                   (timeout_q & ~((wr & sel_timeout) ? PWDATA[NUM_CORES-1:0] : '0));
      for (int i = 0; i < NUM_CORES; i++) begin
        if (cnt_clr) begin
          hit_q[i]  <= '0;
          miss_q[i] <= '0;
        end else if (cnt_en_q) begin
          if (ic_hit_i[i] && hit_q[i] != '1)   hit_q[i]  <= hit_q[i] + CNT_WIDTH'(1);
          if (ic_miss_i[i] && miss_q[i] != '1) miss_q[i] <= miss_q[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign ic_enable_o = enable_q;
  assign irq_o       = done_q & irq_en_q;

endmodule

// File: tb/tb_apb_cache_ctrl_mc.sv
// Self-checking bench for apb_cache_ctrl_mc: directed register/flush/counter
// scenarios with literal expectations, then randomized traffic vs. a model.
module tb_apb_cache_ctrl_mc;

  localparam int AW   = 12;
  localparam int NC   = 4;
  localparam int CW   = 3;
  localparam int TMO  = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic          HCLK    = 1'b0;
  logic          HRESET  = 1'b1;
  logic [AW-1:0] PADDR   = '0;
  logic [31:0]   PWDATA  = '0;
  logic          PWRITE  = 1'b0;
  logic          PSEL    = 1'b0;
  logic          PENABLE = 1'b0;
  logic [31:0]   PRDATA;
  logic          PREADY, PSLVERR, irq_o;
  logic [NC-1:0] ic_enable_o, ic_flush_req_o;
  logic [NC-1:0] ack  = '0;
  logic [NC-1:0] hit  = '0;
  logic [NC-1:0] miss = '0;

  always #5 HCLK = ~HCLK;

  apb_cache_ctrl_mc #(
    .APB_ADDR_WIDTH(AW),
    .NUM_CORES     (NC),
    .CNT_WIDTH     (CW),
    .FLUSH_TIMEOUT (TMO)
  ) dut (
    .HCLK          (HCLK),
    .HRESET        (HRESET),
    .PADDR         (PADDR),
    .PWDATA        (PWDATA),
    .PWRITE        (PWRITE),
    .PSEL          (PSEL),
    .PENABLE       (PENABLE),
    .PRDATA        (PRDATA),
    .PREADY        (PREADY),
    .PSLVERR       (PSLVERR),
    .ic_enable_o   (ic_enable_o),
    .ic_flush_req_o(ic_flush_req_o),
    .ic_flush_ack_i(ack),
    .ic_hit_i      (hit),
    .ic_miss_i     (miss),
    .irq_o         (irq_o)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [NC-1:0] m_en, m_pend, m_tmo;
  bit            m_busy, m_done, m_irqen, m_cnten;
  int            m_core, m_age;  // m_age: cycles the current request has been visible
  int            m_hit  [NC];
  int            m_miss [NC];

  function automatic int lowest(input logic [NC-1:0] p);
    for (int i = 0; i < NC; i++) if (p[i]) return i;
    return 0;
  endfunction

  function automatic logic [NC-1:0] m_req();
    return m_busy ? (NC'(1) << m_core) : '0;
  endfunction

  function automatic bit m_mapped(input logic [AW-1:0] a);
    int off;
    off = int'({a[AW-1:2], 2'b00});
    return (off <= 'h10) || (off >= 'h20 && off < 'h20 + 8 * NC);
  endfunction

  function automatic logic [31:0] m_rdata(input logic [AW-1:0] a);
    int off;
    off = int'({a[AW-1:2], 2'b00});
    case (off)
      'h00: return 32'(m_en);
      'h04: return 32'(m_pend | m_req());
      'h08: return {29'd0, m_irqen, m_done, m_busy};
      'h0C: return 32'(m_tmo);
      'h10: return {31'd0, m_cnten};
      default: begin
        if (off >= 'h20 && off < 'h20 + 8 * NC)
          return (off % 8 == 4) ? 32'(m_miss[(off - 'h20) / 8]) : 32'(m_hit[(off - 'h20) / 8]);
        return 32'd0;
      end
    endcase
  endfunction

  always @(posedge HCLK) begin : model_update
    bit            wr, done_ev, clr_cnt;
    int            off;
    logic [NC-1:0] fset, tset, tclr;
    if (HRESET) begin
      m_en = '0; m_pend = '0; m_tmo = '0;
      m_busy = 0; m_done = 0; m_irqen = 0; m_cnten = 0;
      m_core = 0; m_age = 0;
      for (int i = 0; i < NC; i++) begin m_hit[i] = 0; m_miss[i] = 0; end
    end else begin
      wr      = PSEL && PENABLE && PWRITE;
      off     = int'({PADDR[AW-1:2], 2'b00});
      fset    = (wr && off == 'h04) ? PWDATA[NC-1:0] : '0;
      tclr    = (wr && off == 'h0C) ? PWDATA[NC-1:0] : '0;
      tset    = '0;
      done_ev = 0;
      if (!m_busy) begin
        if (m_pend != '0) begin
          m_core = lowest(m_pend);
          m_pend = (m_pend & ~(NC'(1) << m_core)) | fset;
          m_busy = 1;
          m_age  = 1;
        end else begin
          m_pend = m_pend | fset;
        end
      end else begin
        m_pend = m_pend | fset;
        if (m_age >= 2 && ack[m_core]) begin
          m_busy  = 0;
          done_ev = (m_pend == '0);
        end else if (m_age == TMO + 2) begin
          tset    = NC'(1) << m_core;
          m_busy  = 0;
          done_ev = (m_pend == '0);
        end else begin
          m_age++;
        end
      end
      m_tmo  = (m_tmo & ~tclr) | tset;
      m_done = done_ev || (m_done && !(wr && off == 'h08 && PWDATA[1]));
      if (wr && off == 'h08) m_irqen = PWDATA[2];
      if (wr && off == 'h00) m_en = PWDATA[NC-1:0];
      clr_cnt = wr && off == 'h10 && PWDATA[1];
      for (int i = 0; i < NC; i++) begin
        if (clr_cnt) begin
          m_hit[i] = 0; m_miss[i] = 0;
        end else if (m_cnten) begin
          if (hit[i] && m_hit[i] < CMAX) m_hit[i]++;
          if (miss[i] && m_miss[i] < CMAX) m_miss[i]++;
        end
      end
      if (wr && off == 'h10) m_cnten = PWDATA[0];
    end
  end

  always @(negedge HCLK) begin
    if (chk_en) begin
      check("enable", 32'(ic_enable_o), 32'(m_en));
      check("flush_req", 32'(ic_flush_req_o), 32'(m_req()));
      check("req_onehot0", 32'($onehot0(ic_flush_req_o)), 32'd1);
      check("irq", 32'(irq_o), 32'(m_done && m_irqen));
      check("pready", 32'(PREADY), 32'd1);
      check("prdata", PRDATA, (PSEL && PENABLE) ? m_rdata(PADDR) : 32'd0);
      check("pslverr", 32'(PSLVERR), 32'((PSEL && PENABLE) && !m_mapped(PADDR)));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic apb_write(input logic [AW-1:0] a, input logic [31:0] d);
    @(posedge HCLK); #1 PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
    @(posedge HCLK); #1 PENABLE = 1;
    @(posedge HCLK); #1 PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic apb_read(input logic [AW-1:0] a, output logic [31:0] d, output logic err);
    @(posedge HCLK); #1 PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
    @(posedge HCLK); #1 PENABLE = 1;
    @(negedge HCLK); d = PRDATA; err = PSLVERR;
    @(posedge HCLK); #1 PSEL = 0; PENABLE = 0;
  endtask

  task automatic read_check(input string name, input logic [AW-1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    apb_read(a, d, e);
    check(name, d, exp);
    check({name, "_err"}, 32'(e), 32'd0);
  endtask

  task automatic wait_req(input string name, input logic [NC-1:0] exp);
    int n = 0;
    while (ic_flush_req_o == '0 && n < 100) begin @(negedge HCLK); n++; end
    check(name, 32'(ic_flush_req_o), 32'(exp));
  endtask

  task automatic ack_after(input int dly, input logic [NC-1:0] a);
    repeat (dly) @(posedge HCLK);
    #1 ack = a;
    @(posedge HCLK); #1 ack = '0;
  endtask

  task automatic hit_pulses(input int n, input logic [NC-1:0] m);
    repeat (n) begin
      @(posedge HCLK); #1 hit = m;
      @(posedge HCLK); #1 hit = '0;
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int k;
    logic [AW-1:0] a;
    k = $urandom_range(0, 15);
    if (k <= 4)       a = AW'(4 * k);
    else if (k <= 12) a = AW'('h20 + 4 * (k - 5));
    else if (k == 13) a = AW'('h14);
    else if (k == 14) a = AW'('hFFC);
    else              a = AW'($urandom);
    return a | AW'($urandom_range(0, 3));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    int          n;
    int          ph;

    repeat (3) @(posedge HCLK);
    #1 HRESET = 0;
    chk_en = 1;

    // Reset state and decode
    read_check("rst_enable", 'h00, 0);
    read_check("rst_flush", 'h04, 0);
    read_check("rst_status", 'h08, 0);
    read_check("rst_timeout", 'h0C, 0);
    read_check("rst_cnt_ctrl", 'h10, 0);
    for (int i = 0; i < 2 * NC; i++) read_check("rst_counter", AW'('h20 + 4 * i), 0);
    apb_read('hFFC, d, e);
    check("unmapped_err", 32'(e), 1);
    check("unmapped_data", d, 0);
    apb_read('h14, d, e);
    check("gap_err", 32'(e), 1);

    // Enable register
    apb_write('h00, 32'hA);
    check("enable_out", 32'(ic_enable_o), 32'hA);
    read_check("enable_rb", 'h00, 32'hA);

    // Two-core flush with acks, done interrupt, W1C
    apb_write('h08, 32'h4);
    apb_write('h04, 32'h5);
    wait_req("req_core0_first", 4'b0001);
    ack_after(3, 4'b0001);
    wait_req("req_core2_second", 4'b0100);
    ack_after(3, 4'b0100);
    repeat (2) @(negedge HCLK);
    check("irq_after_done", 32'(irq_o), 1);
    read_check("status_done", 'h08, 32'h6);
    apb_write('h08, 32'h6);
    check("irq_after_w1c", 32'(irq_o), 0);

    // Timeout on an unacknowledged core: 1 REQ cycle + TMO decrements + expiry cycle
    apb_write('h04, 32'h2);
    wait_req("req_core1", 4'b0010);
    n = 0;
    while (ic_flush_req_o != '0 && n < 100) begin @(negedge HCLK); n++; end
    check("req_high_cycles", n, TMO + 2);
    read_check("timeout_flag", 'h0C, 32'h2);
    read_check("status_done_tmo", 'h08, 32'h6);
    apb_write('h0C, 32'h2);
    apb_write('h08, 32'h6);
    read_check("timeout_cleared", 'h0C, 0);

    // Counters: count, saturate, clear-wins
    apb_write('h10, 32'h1);
    hit_pulses(5, 4'b1000);
    read_check("hit3_five", 'h38, 5);
    hit_pulses(5, 4'b1000);
    read_check("hit3_sat", 'h38, 7);
    @(posedge HCLK); #1 PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 'h10; PWDATA = 32'h3;
    @(posedge HCLK); #1 PENABLE = 1; hit = 4'b1000;
    @(posedge HCLK); #1 PSEL = 0; PENABLE = 0; PWRITE = 0; hit = '0;
    read_check("hit3_clr", 'h38, 0);
    read_check("cnt_en_kept", 'h10, 1);

    // Reset while waiting for an ack
    apb_write('h04, 32'h1);
    wait_req("req_before_rst", 4'b0001);
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1;
    @(posedge HCLK); #1 HRESET = 0;
    @(negedge HCLK);
    check("req_after_rst", 32'(ic_flush_req_o), 0);
    read_check("status_after_rst", 'h08, 0);
    read_check("flush_after_rst", 'h04, 0);
    read_check("enable_after_rst", 'h00, 0);

    // Randomized traffic, checked every cycle by the compare process
    ph = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge HCLK); #1;
      for (int b = 0; b < NC; b++) begin
        ack[b]  = ($urandom_range(0, 7) == 0);
        hit[b]  = ($urandom_range(0, 3) == 0);
        miss[b] = ($urandom_range(0, 3) == 0);
      end
      HRESET = ($urandom_range(0, 799) == 0);
      case (ph)
        0: if ($urandom_range(0, 2) == 0) begin
             PSEL = 1; PENABLE = 0; PWRITE = 1'($urandom_range(0, 1));
             PADDR = rand_addr(); PWDATA = $urandom;
             ph = 1;
           end
        1: begin PENABLE = 1; ph = 2; end
        default: begin PSEL = 0; PENABLE = 0; ph = 0; end
      endcase
    end
    @(posedge HCLK); #1;
    PSEL = 0; PENABLE = 0; PWRITE = 0; ack = '0; hit = '0; miss = '0; HRESET = 0;
    repeat (5) @(posedge HCLK);
    @(negedge HCLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_cache_ctrl_mc.md
Name: apb_cache_ctrl_mc

Overview:
- APB slave register block controlling NUM_CORES private instruction caches directly, with no peripheral-bus bridge.
- Provides per-core enable, a queued flush sequencer with ack handshake and timeout, a done interrupt, and per-core saturating hit/miss counters.
- Sits on the APB peripheral tree beside the cluster; drives the cache banks' control inputs.

Parameters:
- APB_ADDR_WIDTH, 12, APB address width (4KB slot).
- NUM_CORES, 4, number of controlled caches, 1..32.
- CNT_WIDTH, 32, hit/miss counter width, 1..32; zero-extended on read.
- FLUSH_TIMEOUT, 1024, max cycles waiting for a flush ack, >=2.

Ports:
- HCLK  in  1  clock
- HRESET  in  1  reset, synchronous, active-high
- PADDR  in  APB_ADDR_WIDTH  APB address
- PWDATA  in  32  write data
- PWRITE  in  1  1 = write
- PSEL  in  1  select
- PENABLE  in  1  access phase
- PRDATA  out  32  read data
- PREADY  out  1  ready
- PSLVERR  out  1  error response
- ic_enable_o  out  NUM_CORES  per-core cache enable
- ic_flush_req_o  out  NUM_CORES  per-core flush request, at most one bit high
- ic_flush_ack_i  in  NUM_CORES  per-core flush ack
- ic_hit_i  in  NUM_CORES  one-cycle hit event pulses
- ic_miss_i  in  NUM_CORES  one-cycle miss event pulses
- irq_o  out  1  level interrupt, = DONE & IRQ_EN

Behaviour:
- Reset (sync, HRESET=1 at HCLK edge):
  - Outputs and registers clear to 0: ENABLE, flush_req, pending, timeout flags, DONE, IRQ_EN, counters, CNT_EN.
  - FSM goes to IDLE.
  - Reset mid-flush drops flush_req the next cycle with no ack wait.
- APB timing:
  - Access = PSEL&PENABLE. PREADY=1 constantly (zero wait states).
  - Writes commit at the access-phase edge.
  - PRDATA is combinational from PADDR during access and 0 otherwise.
  - PSLVERR=1 during access to an unmapped offset. Writes there are ignored; reads return 0.
- Register map (byte offsets, decoded on PADDR[APB_ADDR_WIDTH-1:2]):
  - 0x00 ENABLE, RW, [NUM_CORES-1:0] -> ic_enable_o.
  - 0x04 FLUSH:
    - Write-1-to-set into the pending mask.
    - Read returns pending | active-core bit.
  - 0x08 STATUS:
    - bit0 BUSY (FSM != IDLE), RO.
    - bit1 DONE, W1C.
    - bit2 IRQ_EN, RW.
  - 0x0C TIMEOUT, W1C, [NUM_CORES-1:0] per-core timeout flags.
  - 0x10 CNT_CTRL:
    - bit0 CNT_EN, RW.
    - bit1 CLR, write-1 pulse, reads 0.
  - 0x20+8*i HIT[i], RO; 0x24+8*i MISS[i], RO, for i < NUM_CORES.
  - Constraint: 0x20+8*NUM_CORES <= 2^APB_ADDR_WIDTH.
- Flush FSM, states IDLE -> REQ -> WAIT -> IDLE:
  - IDLE: if pending != 0, latch idx = lowest set bit, clear that pending bit, go to REQ.
  - REQ: assert ic_flush_req_o[idx], load the timer with FLUSH_TIMEOUT, go to WAIT.
  - WAIT: hold req. Timer decrements each cycle. Ack[idx] high drops req next cycle.
  - On timer reaching 0 without ack: set TIMEOUT[idx], drop req.
  - Either exit returns to IDLE.
  - DONE sets on the cycle the FSM returns to IDLE with pending == 0.
- Boundary cases:
  - Minimum latency: 2 cycles FLUSH write -> req; 1 cycle ack -> req low.
  - Acks on non-active cores are ignored.
  - An ack in the same cycle as timer == 0 counts as success; no timeout flag.
  - A FLUSH write of the active core re-queues it; the core is flushed again afterwards.
  - A FLUSH write of an already pending core has no extra effect.
  - A FLUSH write of 0 is a no-op.
  - A DONE W1C in the same cycle as a DONE set: set wins.
  - A FLUSH write in the same cycle as the IDLE pick: the new bits merge into pending and are not lost.
  - Flushing proceeds regardless of ENABLE.
- Counters:
  - When CNT_EN=1, a hit/miss pulse increments its counter.
  - Counters saturate at 2^CNT_WIDTH-1.
  - CLR zeroes all counters and wins over a same-cycle increment.
  - When CNT_EN=0 the counters hold.

Decomposition:
- Package apb_cache_ctrl_pkg: register offset constants, STATUS/CNT_CTRL bit indices, flush FSM state enum.
- One sub-module, cache_flush_seq: the pending mask, FSM, timer, and one-hot lowest-bit pick.
- The top keeps APB decode, registers and counters.

Test Plan:
- Reset, then read all regs -> 0, PSLVERR=0. Read offset 0xFFC -> PSLVERR=1, PRDATA=0.
- Write ENABLE=0xA -> ic_enable_o=4'b1010 the next cycle; readback 0xA.
- Write FLUSH=0x5, ack each core 3 cycles after its req:
  - req[0] high first, then req[2].
  - DONE=1; with IRQ_EN=1, irq_o=1.
  - W1C STATUS=0x2 -> irq_o=0.
- FLUSH=0x2 with no ack, FLUSH_TIMEOUT=16 -> req[1] drops after 16 WAIT cycles; TIMEOUT=0x2; DONE=1.
- CNT_EN=1, 5 hit pulses on core 3 -> HIT[3]=5.
  - CNT_WIDTH=3 with 10 pulses -> 7.
  - CLR with a simultaneous hit -> 0.
- HRESET asserted during WAIT -> flush_req=0, BUSY=0 the next cycle; pending is cleared.
